// File: rtl/subtractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : subtractor_pkg
//  Brief    : Shared types and helpers for the serial ripple-borrow subtractor.
//  Revision : 1.0 - initial release
// ============================================================================
package subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int slice_count(input int nbits, input int bpc);
        return nbits / bpc;
    endfunction

    // A single-slice configuration still needs a one-bit counter.
    function automatic int cnt_width(input int nbits, input int bpc);
        int s;
        s = nbits / bpc;
        return (s > 1) ? $clog2(s) : 1;
    endfunction

    function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                          input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/subtractor_slice.sv
`default_nettype none
// ============================================================================
//  Module   : subtractor_slice
//  Brief    : Combinational ripple-borrow subtractor over one operand slice.
//  Revision : 1.0 - initial release
// ============================================================================
module subtractor_slice #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [BITS_PER_CYCLE-1:0] a,
    input  logic [BITS_PER_CYCLE-1:0] b,
    input  logic                      bin,
    output logic [BITS_PER_CYCLE-1:0] diff,
    output logic                      bout
);

    logic [BITS_PER_CYCLE:0] w_chain;

    assign w_chain[0] = bin;

    generate
        for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_bit
            assign diff[i]      = a[i] ^ b[i] ^ w_chain[i];
            assign w_chain[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_chain[i]);
        end
    endgenerate

    assign bout = w_chain[BITS_PER_CYCLE];

endmodule
`default_nettype wire

// File: rtl/serial_ripple_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_ripple_subtractor
//  Brief    : Multi-cycle A - B - borrowin, BITS_PER_CYCLE bits per cycle,
//             valid/ready handshakes on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_ripple_subtractor
    import subtractor_pkg::*;
#(
    parameter int NUMBITS        = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] A,
    input  logic [NUMBITS-1:0] B,
    input  logic               borrowin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] result,
    output logic               borrowout,
    output logic               overflow,
    output logic               zero
);

    localparam int CNT_W = cnt_width(NUMBITS, BITS_PER_CYCLE);
    localparam logic [CNT_W-1:0] c_last_slice = CNT_W'(slice_count(NUMBITS, BITS_PER_CYCLE) - 1);
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUMBITS-1:0]   r_a;
    logic [NUMBITS-1:0]   r_b;
    logic                 r_borrow;
    logic [NUMBITS-1:0]   r_result;
    logic                 r_borrowout;
    logic                 r_overflow;
    logic                 r_zero;
    logic                 r_a_msb;
    logic                 r_b_msb;

    logic [BITS_PER_CYCLE-1:0] w_diff;
    logic                      w_bout;
    logic [NUMBITS-1:0]        w_result_next;
    logic                      w_last;

    subtractor_slice #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_slice (
        .a    (r_a[BITS_PER_CYCLE-1:0]),
        .b    (r_b[BITS_PER_CYCLE-1:0]),
        .bin  (r_borrow),
        .diff (w_diff),
        .bout (w_bout)
    );

    // Each new slice enters at the MSB end so the LSB slice ends up at bit 0.
    generate
        if (BITS_PER_CYCLE == NUMBITS) begin : g_full
            assign w_result_next = w_diff;
        end else begin : g_shift
            assign w_result_next = {w_diff, r_result[NUMBITS-1:BITS_PER_CYCLE]};
        end
    endgenerate

    assign w_last = (r_cnt == c_last_slice);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_next = ST_BUSY;
            ST_BUSY: if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_borrow    <= 1'b0;
            r_result    <= '0;
            r_borrowout <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_borrow <= borrowin;
                        r_cnt    <= '0;
                        r_a_msb  <= A[NUMBITS-1];
                        r_b_msb  <= B[NUMBITS-1];
                    end
                end
                ST_BUSY: begin
                    r_result <= w_result_next;
                    r_a      <= r_a >> BITS_PER_CYCLE;
                    r_b      <= r_b >> BITS_PER_CYCLE;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + c_one;
                    if (w_last) begin
                        r_borrowout <= w_bout;
                        r_overflow  <= sub_overflow(r_a_msb, r_b_msb, w_result_next[NUMBITS-1]);
                        r_zero      <= (w_result_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign borrowout = r_borrowout;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_ripple_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_ripple_subtractor
//  Brief    : Directed self-checking bench for serial_ripple_subtractor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_ripple_subtractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        bin_in = 1'b0;

    // main instance, BITS_PER_CYCLE = 1
    logic        iv1 = 1'b0, or1 = 1'b0;
    logic        ir1, ov1, bo1, of1, z1;
    logic [15:0] res1;
    // BITS_PER_CYCLE = 4
    logic        iv4 = 1'b0, or4 = 1'b0;
    logic        ir4, ov4, bo4, of4, z4;
    logic [15:0] res4;
    // BITS_PER_CYCLE = 16
    logic        ivw = 1'b0, orw = 1'b0;
    logic        irw, ovw, bow, ofw, zw;
    logic [15:0] resw;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    always #5 clk = ~clk;

    serial_ripple_subtractor #(.NUMBITS(16), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .A(a_in), .B(b_in),
        .borrowin(bin_in), .out_valid(ov1), .out_ready(or1), .result(res1),
        .borrowout(bo1), .overflow(of1), .zero(z1));

    serial_ripple_subtractor #(.NUMBITS(16), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a_in), .B(b_in),
        .borrowin(bin_in), .out_valid(ov4), .out_ready(or4), .result(res4),
        .borrowout(bo4), .overflow(of4), .zero(z4));

    serial_ripple_subtractor #(.NUMBITS(16), .BITS_PER_CYCLE(16)) u_dutw (
        .clk(clk), .rst(rst), .in_valid(ivw), .in_ready(irw), .A(a_in), .B(b_in),
        .borrowin(bin_in), .out_valid(ovw), .out_ready(orw), .result(resw),
        .borrowout(bow), .overflow(ofw), .zero(zw));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation to the main instance, expect completion, then drain.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic bi, input logic [15:0] exp_r, input logic exp_bo,
                          input logic exp_of, input logic exp_z);
        check({tag, "_in_ready"}, 32'(ir1), 32'd1);
        a_in = a; b_in = b; bin_in = bi; iv1 = 1'b1;
        tick();
        iv1 = 1'b0;
        cyc = 1;
        while (!ov1 && cyc < 100) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd17);
        check({tag, "_result"}, 32'(res1), 32'(exp_r));
        check({tag, "_borrowout"}, 32'(bo1), 32'(exp_bo));
        check({tag, "_overflow"}, 32'(of1), 32'(exp_of));
        check({tag, "_zero"}, 32'(z1), 32'(exp_z));
        or1 = 1'b1;
        tick();
        or1 = 1'b0;
        check({tag, "_idle_after"}, 32'(ir1), 32'd1);
    endtask

    initial begin
        // reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(ir1), 32'd1);
        check("rst_out_valid", 32'(ov1), 32'd0);
        check("rst_result", 32'(res1), 32'd0);
        check("rst_flags", {29'd0, bo1, of1, z1}, 32'd0);

        run_op("basic",    16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        run_op("underflow",16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("sovf",     16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op("bin_zero", 16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        run_op("bin_eq",   16'h00FF, 16'h00FF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        // handshake: stray in_valid during BUSY/DONE, stall in DONE
        a_in = 16'h0005; b_in = 16'h0003; bin_in = 1'b0; iv1 = 1'b1;
        tick();
        a_in = 16'hFFFF; b_in = 16'h0000; bin_in = 1'b1;
        tick();
        check("hs_busy_in_ready", 32'(ir1), 32'd0);
        iv1 = 1'b0;
        cyc = 0;
        while (!ov1 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("hs_done_reached", 32'(ov1), 32'd1);
        iv1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hs_stall_valid", 32'(ov1), 32'd1);
            check("hs_stall_in_ready", 32'(ir1), 32'd0);
            check("hs_stall_result", 32'(res1), 32'h0002);
            check("hs_stall_flags", {29'd0, bo1, of1, z1}, 32'd0);
        end
        iv1 = 1'b0;
        or1 = 1'b1;
        tick();
        or1 = 1'b0;
        check("hs_release_in_ready", 32'(ir1), 32'd1);
        check("hs_release_out_valid", 32'(ov1), 32'd0);
        run_op("b2b", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);

        // reset during BUSY slice 7
        a_in = 16'hFFFF; b_in = 16'h1234; bin_in = 1'b0; iv1 = 1'b1;
        tick();
        iv1 = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(ir1), 32'd1);
        check("mid_rst_out_valid", 32'(ov1), 32'd0);
        check("mid_rst_result", 32'(res1), 32'd0);
        check("mid_rst_flags", {29'd0, bo1, of1, z1}, 32'd0);
        run_op("post_rst", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);

        // BITS_PER_CYCLE = 4
        a_in = 16'hA5A5; b_in = 16'h5A5A; bin_in = 1'b0; iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        cyc = 1;
        while (!ov4 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("bpc4_latency", 32'(cyc), 32'd5);
        check("bpc4_result", 32'(res4), 32'h4B4B);
        check("bpc4_flags", {29'd0, bo4, of4, z4}, 32'b010);

        // BITS_PER_CYCLE = 16
        ivw = 1'b1;
        tick();
        ivw = 1'b0;
        cyc = 1;
        while (!ovw && cyc < 100) begin
            tick();
            cyc++;
        end
        check("bpc16_latency", 32'(cyc), 32'd2);
        check("bpc16_result", 32'(resw), 32'h4B4B);
        check("bpc16_flags", {29'd0, bow, ofw, zw}, 32'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
- Multi-cycle ripple-borrow subtractor; computes result = A - B - borrowin over NUMBITS/BITS_PER_CYCLE clock cycles.
- It is the subtract-direction companion to the team's combinational ripple-carry adder, with the same operand and width conventions.
- Operands enter through a valid/ready handshake. Result and flags leave through a valid/ready handshake.
- Used in datapaths where area matters more than latency.

Parameters:
- NUMBITS, 16, operand and result width; must be a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 1, operand bits processed per BUSY cycle (1, 2, 4, 8 or NUMBITS).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  A, B and borrowin are valid this cycle.
- in_ready  output  1  block can accept operands; high only in IDLE.
- A  input  NUMBITS  minuend, unsigned or two's complement.
- B  input  NUMBITS  subtrahend.
- borrowin  input  1  borrow into bit 0.
- out_valid  output  1  result and flags are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- result  output  NUMBITS  A - B - borrowin, modulo 2^NUMBITS.
- borrowout  output  1  set when A < B + borrowin (unsigned).
- overflow  output  1  signed overflow: A[msb] != B[msb] and result[msb] != A[msb].
- zero  output  1  result == 0.

Behaviour:
- States: IDLE, BUSY, DONE; 2-bit encoding.
- Slice counter: width clog2(NUMBITS/BITS_PER_CYCLE), minimum 1.
- Reset (rst=1 at an edge):
  - state goes to IDLE; counter, borrow register, operand shift registers and result go to 0.
  - borrowout, overflow, zero and out_valid go to 0; in_ready reads 1 from the first cycle after reset.
  - Reset takes priority over every other event, including mid-BUSY and DONE. Any in-flight operation is discarded and produces no output.
- in_ready = (state==IDLE), decoded combinationally from state. out_valid = (state==DONE), same.
- IDLE:
  - On in_valid & in_ready: latch A, B, borrowin into the working registers, clear the counter, go to BUSY.
  - Capture the operand sign bits A[msb] and B[msb] for the overflow calculation.
- BUSY, each cycle:
  - Subtract the low BITS_PER_CYCLE bits of the working A and B with the borrow register, rippling the borrow bit by bit.
  - Per-bit rule: d = a ^ b ^ bin; bout = (~a & b) | (~(a ^ b) & bin).
  - Shift the difference slice into result from the MSB end, right-shifting.
  - Shift both operand registers right by BITS_PER_CYCLE.
  - Register the slice borrow-out; increment the counter.
- BUSY exit: after the slice with counter == NUMBITS/BITS_PER_CYCLE-1, go to DONE.
  - On that edge, borrowout takes the final borrow; overflow and zero are computed from the completed result and the captured sign bits.
- Latency: out_valid rises exactly NUMBITS/BITS_PER_CYCLE+1 cycles after the accepting edge (16 cycles of BUSY, then DONE visible).
- in_valid is ignored outside IDLE. Operand inputs need not be held after acceptance.
- DONE:
  - result and all flags are held stable while out_ready=0, with no bound on the stall length.
  - On out_ready=1, go to IDLE.
  - There is no same-cycle re-accept: in_ready is low in DONE, so the next operation is accepted at the earliest one cycle later.
- Width rules:
  - All arithmetic is NUMBITS wide, modulo 2^NUMBITS.
  - borrowin=1 with A=B gives result all-ones and borrowout=1.
  - BITS_PER_CYCLE = NUMBITS gives one BUSY cycle.
- With no transaction in flight, outputs keep the last completed values. Consumers use out_valid to qualify them.

Decomposition:
- Shared package subtractor_pkg:
  - state typedef (IDLE, BUSY, DONE);
  - localparam helper for the slice count and counter width;
  - function sub_overflow(a_msb, b_msb, r_msb).
- One sub-module, subtractor_slice:
  - combinational, parameterised by BITS_PER_CYCLE;
  - inputs a, b, bin; outputs diff, bout;
  - implemented as a ripple-borrow chain using the per-bit rule above.
- The top level contains the FSM, counter, shift registers and flag logic.

Test Plan:
- Basic subtract, NUMBITS=16, BITS_PER_CYCLE=1: A=0x0005, B=0x0003, borrowin=0, accepted at cycle 0 -> out_valid first seen after the 16th BUSY cycle; result=0x0002, borrowout=0, overflow=0, zero=0.
- Underflow and signed overflow:
  - A=0x0000, B=0x0001 -> result=0xFFFF, borrowout=1, overflow=0.
  - A=0x8000, B=0x0001 -> result=0x7FFF, borrowout=0, overflow=1.
- Borrowin and zero: A=0x1234, B=0x1233, borrowin=1 -> result=0x0000, zero=1, borrowout=0; also A=B=0x00FF, borrowin=1 -> result=0xFFFF, borrowout=1.
- Handshake:
  - Hold out_ready=0 for 5 cycles in DONE -> result and flags stable, in_ready=0; in_valid pulses during BUSY/DONE are ignored.
  - Raise out_ready -> IDLE next cycle, and a back-to-back operation is accepted in that IDLE cycle.
- Reset mid-operation: assert rst at BUSY slice 7 -> next cycle state=IDLE, in_ready=1, out_valid=0, all outputs 0; the following operation 0x0010-0x0001 gives 0x000F.
- Parameter sweep, BITS_PER_CYCLE=4: A=0xA5A5, B=0x5A5A -> result=0x4B4B, borrowout=0, overflow=1, out_valid 5 cycles after accept; repeat with BITS_PER_CYCLE=16 -> 2-cycle latency, same values.
